// File: rtl/rails_pkg.sv
// Shared types and elaboration-time width helpers for the rails order checker.
package rails_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    // Index width for an array of 'depth' entries (never zero).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit width_ok(input int dw, input int max_n);
        return (max_n >= 1) && ((dw >= 31) || ((1 << dw) > max_n));
    endfunction

endpackage

// File: rtl/rails_lifo.sv
// Small LIFO with a registered top-of-stack; clr wins over push and pop.
module rails_lifo
    import rails_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int AW  = idx_w(DEPTH);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic [SPW-1:0] sp_q, sp_d, sp_m2;
    logic [DW-1:0]  top_q, top_d;

    assign empty = (sp_q == '0);
    assign full  = (sp_q == SPW'(DEPTH));
    assign top   = top_q;
    assign sp_m2 = sp_q - SPW'(2);

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        top_d = top_q;
        if (clr) begin
            sp_d  = '0;
            top_d = '0;
        end else if (push && !full) begin
            mem_d[sp_q[AW-1:0]] = din;
            sp_d  = sp_q + SPW'(1);
            top_d = din;
        end else if (pop && !empty) begin
            // The entry below the current top becomes the new registered top.
            sp_d  = sp_q - SPW'(1);
            top_d = (sp_q > SPW'(1)) ? mem_q[sp_m2[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            top_q <= '0;
        end else begin
            sp_q  <= sp_d;
            top_q <= top_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full && !clr)) else $error("rails_lifo: push on full stack");
            assert (!(push && pop)) else $error("rails_lifo: simultaneous push and pop");
        end
    end

endmodule

// File: rtl/rails_param_checker.sv
// Decides whether a framed train exit order can be produced through one LIFO
// station: loads n and the order, replays it against a stack, pulses the verdict.
module rails_param_checker
    import rails_pkg::*;
#(
    parameter int MAX_N = 10,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] data,
    output logic          in_ready,
    output logic          valid,
    output logic          result
);
    if (!width_ok(DW, MAX_N)) begin : g_bad_width
        $error("rails_param_checker: need MAX_N >= 1 and 2**DW > MAX_N");
    end

    localparam int AW = idx_w(MAX_N);
    localparam int CW = DW + 1;

    state_t        state_q, state_d;
    logic [DW-1:0] n_q, n_d;
    logic          bad_q, bad_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] nxt_q, nxt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          result_q, result_d;
    logic [DW-1:0] buf_q [MAX_N];
    logic [DW-1:0] buf_d [MAX_N];

    logic [CW-1:0] load_len;
    logic [DW-1:0] t, top;
    logic          push, pop, clr, empty, full;

    // Oversized frames are still drained, but only MAX_N beats of them.
    assign load_len = ({1'b0, n_q} > CW'(MAX_N)) ? CW'(MAX_N) : {1'b0, n_q};
    assign t        = buf_q[idx_q[AW-1:0]];
    assign valid    = (state_q == DONE);
    assign result   = result_q;

    rails_lifo #(.DEPTH(MAX_N), .DW(DW)) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (nxt_q[DW-1:0]),
        .top   (top),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        nxt_d    = nxt_q;
        idx_d    = idx_q;
        result_d = result_q;
        buf_d    = buf_q;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    n_d     = data;
                    bad_d   = (data == '0) || ({1'b0, data} > CW'(MAX_N));
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // n==0 has nothing to consume: hold off the feeder and report.
                if (load_len == '0) begin
                    result_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        buf_d[cnt_q[AW-1:0]] = data;
                        bad_d = bad_q || (data == '0) || (data > n_q);
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == load_len - CW'(1)) begin
                            if (bad_d) begin
                                result_d = 1'b0;
                                state_d  = DONE;
                            end else begin
                                nxt_d   = CW'(1);
                                idx_d   = '0;
                                state_d = CHECK;
                            end
                        end
                    end
                end
            end
            CHECK: begin
                if (!empty && top == t) begin
                    pop   = 1'b1;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == {1'b0, n_q} - CW'(1)) begin
                        result_d = 1'b1;
                        state_d  = DONE;
                    end
                end else if (nxt_q <= {1'b0, t} && !full) begin
                    push  = 1'b1;
                    nxt_d = nxt_q + CW'(1);
                end else begin
                    // Wanted train is buried under a larger one.
                    result_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                clr     = 1'b1;
                cnt_d   = '0;
                nxt_d   = CW'(1);
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
            nxt_q    <= CW'(1);
            idx_q    <= '0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            nxt_q    <= nxt_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_rails_param_checker.sv
// Directed and randomised frames against rails_param_checker; verdicts are
// checked from an expected-result queue as valid pulses appear.
module tb_rails_param_checker;
    localparam int MAX_N = 10;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] data;
    logic          in_ready, valid, result;

    int    checks = 0, errors = 0, cyc = 0, acc_cyc = 0, nvalid = 0;
    int    v0, v1;
    bit    lat_on = 1'b0;
    bit    exp_r;
    string tag_r;
    bit    expq [$];
    string tagq [$];
    int    fv [16];

    rails_param_checker #(.MAX_N(MAX_N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .data     (data),
        .in_ready (in_ready),
        .valid    (valid),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Each valid pulse consumes one expected verdict; a pulse with none queued is an error.
    always @(negedge clk) begin
        if (!reset && valid) begin
            nvalid++;
            if (expq.size() == 0) begin
                chk("unexpected_valid", valid, 0);
            end else begin
                exp_r = expq.pop_front();
                tag_r = tagq.pop_front();
                chk(tag_r, result, exp_r);
                chk("ready_low_in_done", in_ready, 0);
                if (lat_on) chk("t1_latency_le_10", (cyc - acc_cyc) <= 10, 1);
            end
        end
    end

    // Exit order contains no a..b..c with b < c < a (the 312 pattern).
    function automatic bit ref_reach(input int n);
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                for (int k = j + 1; k < n; k++)
                    if (fv[j] < fv[k] && fv[k] < fv[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic setv(input int a0 = 0, input int a1 = 0, input int a2 = 0, input int a3 = 0,
                        input int a4 = 0, input int a5 = 0, input int a6 = 0, input int a7 = 0,
                        input int a8 = 0, input int a9 = 0);
        fv[0] = a0; fv[1] = a1; fv[2] = a2; fv[3] = a3; fv[4] = a4;
        fv[5] = a5; fv[6] = a6; fv[7] = a7; fv[8] = a8; fv[9] = a9;
    endtask

    task automatic send_beat(input int v, input int gap);
        int w;
        bit acc;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        data     = DW'(v);
        w   = 0;
        acc = 1'b0;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) acc_cyc = cyc + 1;
            @(posedge clk); #1;
            w++;
        end
        if (!acc) chk("beat_accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input int n, input int cnt, input int gapmax, input bit hold);
        send_beat(n, $urandom_range(0, gapmax));
        for (int i = 0; i < cnt; i++) send_beat(fv[i], $urandom_range(0, gapmax));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (expq.size() != 0 && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk(tag, expq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input bit e, input int n, input int cnt);
        expq.push_back(e);
        tagq.push_back(tag);
        send_frame(n, cnt, 0, 1'b0);
        drain({tag, "_drain"});
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gm, j, tmp;
        reset    = 1'b1;
        in_valid = 1'b0;
        data     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_result", result, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1 / T2: basic reachable and unreachable orders
        lat_on = 1'b1;
        setv(1, 2, 3, 4, 5);       run("t1_12345", 1'b1, 5, 5);
        lat_on = 1'b0;
        setv(5, 4, 1, 2, 3);       run("t2_54123", 1'b0, 5, 5);
        setv(3, 1, 2);             run("t2_312", 1'b0, 3, 3);
        setv(2, 3, 1);             run("t2_231", 1'b1, 3, 3);

        // T3: full-depth descending order fills the stack exactly
        setv(10, 9, 8, 7, 6, 5, 4, 3, 2, 1); run("t3_desc_max", 1'b1, MAX_N, MAX_N);

        // T4: illegal frames
        v0 = nvalid;
        run("t4_n0", 1'b0, 0, 0);
        setv(1, 2, 3, 4, 5, 6, 7, 8, 9, 10); run("t4_n_over", 1'b0, MAX_N + 1, MAX_N);
        setv(1, 4, 2);             run("t4_value_over_n", 1'b0, 3, 3);
        setv(2, 2, 1);             run("t4_duplicate", 1'b0, 3, 3);
        chk("t4_one_valid_per_frame", nvalid - v0, 4);

        // T5: resets abort frames mid-LOAD and mid-CHECK
        v1 = nvalid;
        send_beat(4, 0); send_beat(1, 0); send_beat(2, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_load_rst_ready", in_ready, 1);
        chk("t5_load_rst_valid", valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        setv(10, 9, 8, 7, 6, 5, 4, 3, 2, 1);
        send_frame(MAX_N, MAX_N, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_in_ready_low_check", in_ready, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_valid_aborted", nvalid - v1, 0);
        setv(2, 1);                run("t5_clean_21", 1'b1, 2, 2);

        // T6: back-to-back random permutations, then random in_valid gaps
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(1, MAX_N);
            for (int i = 0; i < n; i++) fv[i] = i + 1;
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = fv[i]; fv[i] = fv[j]; fv[j] = tmp;
            end
            expq.push_back(ref_reach(n));
            tagq.push_back("t6_random");
            gm = (f < 300) ? 0 : 3;
            send_frame(n, n, gm, f != 999);
        end
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
